// File: rtl/aer_frame_streamer.sv
// AER frame streamer: stores a TIME_STEP x FM_C x FM_H x FM_W spike bitmap and
// replays it as 4-phase AER events {type,c,y,x}. After each timestep it sends an
// end-of-timestep marker, and it can optionally send an end-of-sample marker at
// the end. The ACK input is synchronised, and a stalled handshake aborts with a
// sticky err flag.
module aer_frame_streamer #(
  parameter int FM_W        = 16,
  parameter int FM_H        = 16,
  parameter int FM_C        = 3,
  parameter int TIME_STEP   = 8,
  parameter int SETUP_CYC   = 2,
  parameter int ACK_TIMEOUT = 1024,
  parameter int SEND_EOS    = 1,
  localparam int XW  = (FM_W > 1) ? $clog2(FM_W) : 1,
  localparam int YW  = (FM_H > 1) ? $clog2(FM_H) : 1,
  localparam int CW  = (FM_C > 1) ? $clog2(FM_C) : 1,
  localparam int TW  = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1,
  localparam int PW  = CW + YW + XW,
  localparam int AW  = 2 + PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [TW-1:0] wr_t,
  input  logic [PW-1:0] wr_pix,
  input  logic          wr_bit,
  input  logic          start,
  input  logic          sparse,
  output logic          AER_REQ,
  output logic [AW-1:0] AER_ADDR,
  input  logic          AER_ACK,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [TW-1:0] cur_t
);

  localparam int NBITS = (1 << (TW + PW));
  localparam int SCW   = $clog2(SETUP_CYC + 1);
  localparam int TOW   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [XW-1:0]  X_LAST     = XW'(FM_W - 1);
  localparam logic [YW-1:0]  Y_LAST     = YW'(FM_H - 1);
  localparam logic [CW-1:0]  C_LAST     = CW'(FM_C - 1);
  localparam logic [TW-1:0]  T_LAST     = TW'(TIME_STEP - 1);
  localparam logic [XW:0]    X_NUM      = (XW + 1)'(FM_W);
  localparam logic [YW:0]    Y_NUM      = (YW + 1)'(FM_H);
  localparam logic [CW:0]    C_NUM      = (CW + 1)'(FM_C);
  localparam logic [TW:0]    T_NUM      = (TW + 1)'(TIME_STEP);
  localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYC - 1);
  localparam logic [TOW-1:0] TMO_LAST   = TOW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SETUP, S_REQ, S_ACKLO, S_EOT, S_EOS, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [CW-1:0]   c_q, c_d;
  logic [YW-1:0]   y_q, y_d;
  logic [XW-1:0]   x_q, x_d;
  logic            sparse_q, sparse_d;
  logic            req_q, req_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [SCW-1:0]  setup_q, setup_d;
  logic [TOW-1:0]  tmo_q, tmo_d;
  logic            ack_m_q, ack_s_q;
  logic [NBITS-1:0] bitmap_q;

  logic [CW-1:0]   wr_c_s;
  logic [YW-1:0]   wr_y_s;
  logic [XW-1:0]   wr_x_s;
  logic            wr_ok_s;
  logic            bit_s;
  logic            last_pix_s;
  logic [CW-1:0]   adv_c_s;
  logic [YW-1:0]   adv_y_s;
  logic [XW-1:0]   adv_x_s;

  assign wr_c_s  = wr_pix[PW-1 -: CW];
  assign wr_y_s  = wr_pix[XW +: YW];
  assign wr_x_s  = wr_pix[XW-1:0];
  // Writes are only taken while idle, and only for pixel/timestep codes that exist.
  assign wr_ok_s = wr_en && !busy_q &&
                   ({1'b0, wr_c_s} < C_NUM) && ({1'b0, wr_y_s} < Y_NUM) &&
                   ({1'b0, wr_x_s} < X_NUM) && ({1'b0, wr_t} < T_NUM);
  assign bit_s      = bitmap_q[{t_q, c_q, y_q, x_q}];
  assign last_pix_s = (c_q == C_LAST) && (y_q == Y_LAST) && (x_q == X_LAST);

  // Spike bitmap storage; not reset, contents are defined only by host writes
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      bitmap_q[{wr_t, wr_pix}] <= wr_bit;
    end
  end

  // Two-flop synchroniser for the asynchronous acknowledge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_m_q <= 1'b0;
      ack_s_q <= 1'b0;
    end else begin
      ack_m_q <= AER_ACK;
      ack_s_q <= ack_m_q;
    end
  end

  // Next pixel in scan order: x fastest, then y, then c
  always_comb begin
    adv_x_s = x_q + 1'b1;
    adv_y_s = y_q;
    adv_c_s = c_q;
    if (x_q == X_LAST) begin
      adv_x_s = {XW{1'b0}};
      if (y_q == Y_LAST) begin
        adv_y_s = {YW{1'b0}};
        adv_c_s = c_q + 1'b1;
      end else begin
        adv_y_s = y_q + 1'b1;
      end
    end else begin
      adv_x_s = x_q + 1'b1;
    end
  end

  // FSM next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    c_d      = c_q;
    y_d      = y_q;
    x_d      = x_q;
    sparse_d = sparse_q;
    req_d    = req_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    setup_d  = setup_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !ack_s_q) begin
          sparse_d = sparse;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          t_d      = {TW{1'b0}};
          c_d      = {CW{1'b0}};
          y_d      = {YW{1'b0}};
          x_d      = {XW{1'b0}};
          state_d  = S_SCAN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SCAN: begin
        if (!sparse_q || bit_s) begin
          addr_d  = {2'b00, c_q, y_q, x_q};
          setup_d = {SCW{1'b0}};
          state_d = S_SETUP;
        end else if (last_pix_s) begin
          state_d = S_EOT;
        end else begin
          c_d = adv_c_s;
          y_d = adv_y_s;
          x_d = adv_x_s;
        end
      end
      S_SETUP: begin
        if (setup_q == SETUP_LAST) begin
          req_d   = 1'b1;
          tmo_d   = {TOW{1'b0}};
          state_d = S_REQ;
        end else begin
          setup_d = setup_q + 1'b1;
        end
      end
      S_REQ: begin
        if (ack_s_q) begin
          req_d   = 1'b0;
          tmo_d   = {TOW{1'b0}};
          state_d = S_ACKLO;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
      end
      S_ACKLO: begin
        if (!ack_s_q) begin
          case (addr_q[AW-1 -: 2])
            2'b00: begin
              if (last_pix_s) begin
                state_d = S_EOT;
              end else begin
                c_d     = adv_c_s;
                y_d     = adv_y_s;
                x_d     = adv_x_s;
                state_d = S_SCAN;
              end
            end
            2'b01: begin
              if (t_q == T_LAST) begin
                state_d = (SEND_EOS != 0) ? S_EOS : S_DONE;
              end else begin
                t_d     = t_q + 1'b1;
                c_d     = {CW{1'b0}};
                y_d     = {YW{1'b0}};
                x_d     = {XW{1'b0}};
                state_d = S_SCAN;
              end
            end
            default: state_d = S_DONE;
          endcase
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
      end
      S_EOT: begin
        // Marker carries the last scanned pixel, which the counters still hold.
        addr_d  = {2'b01, c_q, y_q, x_q};
        setup_d = {SCW{1'b0}};
        state_d = S_SETUP;
      end
      S_EOS: begin
        addr_d  = {2'b10, {PW{1'b0}}};
        setup_d = {SCW{1'b0}};
        state_d = S_SETUP;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      t_q      <= {TW{1'b0}};
      c_q      <= {CW{1'b0}};
      y_q      <= {YW{1'b0}};
      x_q      <= {XW{1'b0}};
      sparse_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= {AW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      setup_q  <= {SCW{1'b0}};
      tmo_q    <= {TOW{1'b0}};
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      c_q      <= c_d;
      y_q      <= y_d;
      x_q      <= x_d;
      sparse_q <= sparse_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      setup_q  <= setup_d;
      tmo_q    <= tmo_d;
    end
  end

  assign AER_REQ  = req_q;
  assign AER_ADDR = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cur_t    = t_q;

endmodule

// File: tb/tb_aer_frame_streamer.sv
// Directed bench for aer_frame_streamer at default parameters (16x16x3, 8 steps).
module tb_aer_frame_streamer;

  localparam int SETUP = 2;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, wr_bit, start, sparse, ack;
  logic [2:0]  wr_t;
  logic [9:0]  wr_pix;
  logic        req, busy, done, err;
  logic [11:0] addr;
  logic [2:0]  cur_t;

  int total = 0;
  int bad = 0;
  int ack_mode = 1;     // 0 auto responder, 1 hold low, 2 hold high
  int ack_dly = 0;
  int done_cnt = 0;
  int setup_viol = 0;
  int hold_viol = 0;
  logic [14:0] ev_q[$];

  logic        prev_req = 1'b0;
  logic [11:0] prev_addr = 12'h000;
  int          stable = 0;
  logic        hs = 1'b0;
  int          dcnt = 0;

  aer_frame_streamer dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_t(wr_t), .wr_pix(wr_pix),
    .wr_bit(wr_bit), .start(start), .sparse(sparse), .AER_REQ(req),
    .AER_ADDR(addr), .AER_ACK(ack), .busy(busy), .done(done), .err(err),
    .cur_t(cur_t)
  );

  always #5 clk = ~clk;

  // Monitor and ACK responder, sampling on the falling edge.
  initial begin
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs = 1'b0;
        stable = 0;
      end else begin
        if (addr !== prev_addr) begin
          if (hs) hold_viol++;
          stable = 0;
        end else if (stable < 100000) begin
          stable++;
        end
        if (req && !prev_req) begin
          ev_q.push_back({cur_t, addr});
          if (stable < SETUP) setup_viol++;
          hs = 1'b1;
        end
        if (!req && !ack) hs = 1'b0;
        if (done) done_cnt++;
      end
      prev_req = req;
      prev_addr = addr;
      case (ack_mode)
        0: begin
          if (req && !ack) begin
            if (dcnt >= ack_dly) ack = 1'b1;
            else dcnt++;
          end else begin
            dcnt = 0;
            if (!req && ack) ack = 1'b0;
          end
        end
        1: ack = 1'b0;
        default: ack = 1'b1;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int bound, input int base, input string tag);
    int n = 0;
    while (done_cnt == base && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done_cnt != base), 32'd1);
  endtask

  task automatic wait_req(input int bound, input string tag);
    int n = 0;
    while (!req && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(req), 32'd1);
  endtask

  initial begin
    logic [14:0] exp_sp [11];
    logic [14:0] got, expv;
    int base, n, k, mism, first_bad;

    exp_sp = '{15'h0025, 15'h06FF, 15'h16FF, 15'h26FF, 15'h32FF, 15'h36FF,
               15'h46FF, 15'h56FF, 15'h66FF, 15'h76FF, 15'h7800};
    rst_n = 1'b0; wr_en = 1'b0; wr_t = 3'd0; wr_pix = 10'd0; wr_bit = 1'b0;
    start = 1'b0; sparse = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cur_t", 32'(cur_t), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clear the whole bitmap, then set two spikes.
    wr_en = 1'b1; wr_bit = 1'b0;
    for (int t = 0; t < 8; t++) begin
      for (int p = 0; p < 768; p++) begin
        wr_t = 3'(t); wr_pix = 10'(p);
        @(negedge clk);
      end
    end
    wr_bit = 1'b1;
    wr_t = 3'd0; wr_pix = 10'h025; @(negedge clk);
    wr_t = 3'd3; wr_pix = 10'h2FF; @(negedge clk);
    wr_en = 1'b0; wr_bit = 1'b0;

    // Sparse run; a write and a start issued while busy must have no effect.
    ack_mode = 0; ack_dly = 10; ev_q.delete(); base = done_cnt;
    sparse = 1'b1; start = 1'b1; @(negedge clk);
    start = 1'b0; sparse = 1'b0;
    chk("sparse_busy", 32'(busy), 32'd1);
    wr_en = 1'b1; wr_t = 3'd5; wr_pix = 10'h111; wr_bit = 1'b1; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; wr_bit = 1'b0; start = 1'b0;
    wait_done(20000, base, "sparse_done_seen");
    chk("sparse_count", 32'(ev_q.size()), 32'd11);
    for (int i = 0; i < 11; i++) begin
      got = (i < ev_q.size()) ? ev_q[i] : 15'h7FFF;
      chk($sformatf("sparse_ev%0d", i), 32'(got), 32'(exp_sp[i]));
    end
    chk("sparse_done_once", 32'(done_cnt - base), 32'd1);
    chk("sparse_err", 32'(err), 32'd0);
    chk("sparse_busy_end", 32'(busy), 32'd0);

    // Start while synchronised ACK is high is ignored.
    ack_mode = 2; repeat (4) @(negedge clk);
    sparse = 1'b1; start = 1'b1; @(negedge clk);
    start = 1'b0; @(negedge clk);
    chk("start_ack_high", 32'(busy), 32'd0);
    ack_mode = 1; repeat (4) @(negedge clk);

    // ACK never rises: abort exactly ACK_TIMEOUT cycles after REQ rise.
    base = done_cnt;
    start = 1'b1; @(negedge clk);
    start = 1'b0;
    wait_req(1000, "tmo_req_rise");
    n = 0;
    while (req && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd1024);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_no_done", 32'(done_cnt - base), 32'd0);

    // Next start clears err; reset while REQ=1 and ACK=1.
    start = 1'b1; @(negedge clk);
    start = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_req(1000, "rst_req_rise");
    ack_mode = 2;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ack_mode = 1; sparse = 1'b0;
    repeat (4) @(negedge clk);

    // Dense run restarting from t=0, pixel 0.
    ev_q.delete(); base = done_cnt; setup_viol = 0; hold_viol = 0;
    start = 1'b1; @(negedge clk);
    start = 1'b0; ack_mode = 0; ack_dly = 0;
    chk("dense_busy", 32'(busy), 32'd1);
    chk("dense_cur_t", 32'(cur_t), 32'd0);
    wait_done(60000, base, "dense_done_seen");
    chk("dense_count", 32'(ev_q.size()), 32'd6153);
    got = (ev_q.size() > 0) ? ev_q[0] : 15'h7FFF;
    chk("dense_first", 32'(got), 32'd0);
    k = 0; mism = 0; first_bad = -1;
    for (int t = 0; t < 8; t++) begin
      for (int p = 0; p <= 768; p++) begin
        expv = (p < 768) ? {3'(t), 12'(p)} : {3'(t), 12'h6FF};
        got = (k < ev_q.size()) ? ev_q[k] : 15'h7FFF;
        if (got !== expv) begin
          mism++;
          if (first_bad < 0) first_bad = k;
        end
        k++;
      end
    end
    got = (k < ev_q.size()) ? ev_q[k] : 15'h7FFF;
    if (got !== 15'h7800) begin
      mism++;
      if (first_bad < 0) first_bad = k;
    end
    chk("dense_order_mism", 32'(mism), 32'd0);
    chk("dense_done_once", 32'(done_cnt - base), 32'd1);
    chk("dense_err", 32'(err), 32'd0);
    chk("setup_viol", 32'(setup_viol), 32'd0);
    chk("hold_viol", 32'(hold_viol), 32'd0);
    if (first_bad >= 0) $display("first dense discrepancy at event %0d", first_bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
